pe_ctrl: RTL

PE_CTRL -- requirements
Module: pe_ctrl

---
 rtl/pe_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pe_ctrl.sv
// Dot-product sequencer for a single MAC processing element: streams B into PE RAM,
// then issues one A element at a time and accumulates the PE result.
module pe_ctrl #(
    parameter int L_RAM_SIZE = 6,
    parameter int MAC_LAT    = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [L_RAM_SIZE:0]   len,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [31:0]           pe_din,
    output logic [31:0]           pe_ain,
    output logic [31:0]           pe_cin,
    output logic                  pe_valid,
    input  logic [31:0]           pe_dout,
    output logic [31:0]           result,
    output logic                  done,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ACC   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAC_LAT - 1);
    localparam logic [L_RAM_SIZE:0] MAX_N = {1'b1, {L_RAM_SIZE{1'b0}}};

    logic [2:0]            state;
    logic [31:0]           acc;
    logic [L_RAM_SIZE:0]   n;
    logic [L_RAM_SIZE:0]   k;
    logic [L_RAM_SIZE:0]   load_cnt;
    logic [WW-1:0]         wait_cnt;
    logic [L_RAM_SIZE:0]   k_inc;
    logic [L_RAM_SIZE:0]   load_inc;

    assign k_inc     = k + (L_RAM_SIZE + 1)'(1);
    assign load_inc  = load_cnt + (L_RAM_SIZE + 1)'(1);
    assign dbg_state = state;

    // s_valid/s_ready: a beat transfers on a rising edge where both are high.
    // s_ready is registered and only raised in LOAD and FETCH.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= S_IDLE;
            acc      <= '0;
            n        <= '0;
            k        <= '0;
            load_cnt <= '0;
            wait_cnt <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            s_ready  <= 1'b0;
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;
            pe_addr  <= '0;
            pe_ain   <= '0;
            pe_cin   <= '0;
            pe_din   <= '0;
        end else begin
            done     <= 1'b0;
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        k    <= '0;
                        busy <= 1'b1;
                        if (len == '0) begin
                            state <= S_DONE;
                        end else begin
                            n        <= (len > MAX_N) ? MAX_N : len;
                            load_cnt <= '0;
                            s_ready  <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // After the last B beat, one drain cycle lets its write land before FETCH.
                    if (load_cnt == n) begin
                        s_ready <= 1'b1;
                        pe_addr <= k[L_RAM_SIZE-1:0];
                        state   <= S_FETCH;
                    end else if (s_valid && s_ready) begin
                        pe_we    <= 1'b1;
                        pe_addr  <= load_cnt[L_RAM_SIZE-1:0];
                        pe_din   <= s_data;
                        load_cnt <= load_inc;
                        if (load_inc == n) begin
                            s_ready <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    if (s_valid && s_ready) begin
                        pe_ain   <= s_data;
                        pe_cin   <= acc;
                        s_ready  <= 1'b0;
                        pe_valid <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_ACC;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_ACC: begin
                    acc <= pe_dout;
                    k   <= k_inc;
                    if (k_inc == n) begin
                        state <= S_DONE;
                    end else begin
                        s_ready <= 1'b1;
                        pe_addr <= k_inc[L_RAM_SIZE-1:0];
                        state   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
